ar_issue_arbiter: RTL and testbench

- Arbitrates the DRAM read-address (AR) channel between two requesters: demand reads passed through from the accelerator, and prefetch reads generated by the prefetcher control path.
- Sits between the prefetcher top and the AXI RAM/DDR slave. Drives a single registered master AR port.
- Demand has fixed priority. A starvation counter guarantees prefetch progress.
- Caps the number of bursts in flight at the DRAM by counting R-channel last beats.

---
 rtl/ar_issue_arbiter_if.sv | 64 ++++++
 rtl/ar_issue_arbiter.sv | 138 +++++++++++++
 tb/tb_ar_issue_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ar_issue_arbiter_if.sv
// Handshake bundle for the AR issue arbiter: demand and prefetch request
// channels, the registered master AR port, R-channel completion monitor,
// and the status outputs. The arbiter connects through the master modport;
// the surrounding fabric (or a bench) uses the slave modport.
interface ar_issue_arbiter_if #(
    parameter int ADDR_BITS       = 64,
    parameter int TID_WIDTH       = 8,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int OUTST_WIDTH     = 3
);
    logic                       en;

    logic                       dm_ar_valid;
    logic                       dm_ar_ready;
    logic [ADDR_BITS-1:0]       dm_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] dm_ar_len;
    logic [TID_WIDTH-1:0]       dm_ar_id;

    logic                       pf_ar_valid;
    logic                       pf_ar_ready;
    logic [ADDR_BITS-1:0]       pf_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] pf_ar_len;
    logic [TID_WIDTH-1:0]       pf_ar_id;

    logic                       m_ar_valid;
    logic                       m_ar_ready;
    logic [ADDR_BITS-1:0]       m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len;
    logic [TID_WIDTH-1:0]       m_ar_id;
    logic                       m_ar_src;

    logic                       m_r_valid;
    logic                       m_r_ready;
    logic                       m_r_last;

    logic [OUTST_WIDTH-1:0]     outstanding;
    logic                       err_underflow;

    // Arbiter side
    modport master (
        input  en,
        input  dm_ar_valid, dm_ar_addr, dm_ar_len, dm_ar_id,
        output dm_ar_ready,
        input  pf_ar_valid, pf_ar_addr, pf_ar_len, pf_ar_id,
        output pf_ar_ready,
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_ar_src,
        input  m_ar_ready,
        input  m_r_valid, m_r_ready, m_r_last,
        output outstanding, err_underflow
    );

    // Requesters, DRAM slave and status consumer side
    modport slave (
        output en,
        output dm_ar_valid, dm_ar_addr, dm_ar_len, dm_ar_id,
        input  dm_ar_ready,
        output pf_ar_valid, pf_ar_addr, pf_ar_len, pf_ar_id,
        input  pf_ar_ready,
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_ar_src,
        output m_ar_ready,
        output m_r_valid, m_r_ready, m_r_last,
        input  outstanding, err_underflow
    );
endinterface

// File: rtl/ar_issue_arbiter.sv
// AR issue arbiter: demand reads win by fixed priority, a starvation counter
// forces a prefetch grant after STARVE_LIMIT consecutive demand wins, and an
// outstanding-burst counter (fed by R last beats) caps bursts in flight.
// The master AR port is a single registered slot that supports one issue
// per cycle when m_ar_ready is held high.
//
// state | meaning
// IDLE  | output register empty, m_ar_valid=0
// HOLD  | m_ar_valid=1, payload held stable until m_ar_ready
module ar_issue_arbiter #(
    parameter int ADDR_BITS       = 64,
    parameter int TID_WIDTH       = 8,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int STARVE_LIMIT    = 4,
    parameter int OUTST_WIDTH     = 3
) (
    input  logic clk,
    input  logic rst,
    ar_issue_arbiter_if.master bus
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]        STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [OUTST_WIDTH-1:0] OUTST_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_BITS-1:0]       addr_q, addr_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
    logic [TID_WIDTH-1:0]       id_q, id_d;
    logic                       src_q, src_d;
    logic [SC_W-1:0]            starve_q, starve_d;
    logic [OUTST_WIDTH-1:0]     outst_q, outst_d;
    logic                       err_q, err_d;

    logic slot_free;
    logic cap_ok;
    logic pf_elig;
    logic pf_win;
    logic dm_win;
    logic grant;
    logic r_done;

    // Grant decision: demand first unless prefetch has waited STARVE_LIMIT grants
    always_comb begin
        slot_free = (state_q == IDLE) | bus.m_ar_ready;
        cap_ok    = (outst_q != OUTST_MAX);
        pf_elig   = bus.pf_ar_valid & bus.en;
        pf_win    = slot_free & cap_ok & pf_elig &
                    (~bus.dm_ar_valid | (starve_q == STARVE_MAX));
        dm_win    = slot_free & cap_ok & bus.dm_ar_valid & ~pf_win;
        grant     = pf_win | dm_win;
        r_done    = bus.m_r_valid & bus.m_r_ready & bus.m_r_last;
    end

    // Next-state for the output slot, starvation counter and burst counter
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        id_d     = id_q;
        src_d    = src_q;
        starve_d = starve_q;
        outst_d  = outst_q;
        err_d    = err_q;

        if (pf_win) begin
            state_d = HOLD;
            addr_d  = bus.pf_ar_addr;
            len_d   = bus.pf_ar_len;
            id_d    = bus.pf_ar_id;
            src_d   = 1'b1;
        end else if (dm_win) begin
            state_d = HOLD;
            addr_d  = bus.dm_ar_addr;
            len_d   = bus.dm_ar_len;
            id_d    = bus.dm_ar_id;
            src_d   = 1'b0;
        end else if ((state_q == HOLD) && bus.m_ar_ready) begin
            // Payload is left as-is; it is invisible once valid drops.
            state_d = IDLE;
        end

        if (!pf_elig || pf_win) begin
            starve_d = '0;
        end else if (dm_win && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end

        if (grant && !r_done) begin
            outst_d = outst_q + 1'b1;
        end else if (r_done && !grant) begin
            if (outst_q == '0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_q - 1'b1;
            end
        end
    end

    // State and output registers; reset discards any held request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            src_q    <= 1'b0;
            starve_q <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            id_q     <= id_d;
            src_q    <= src_d;
            starve_q <= starve_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

    assign bus.dm_ar_ready   = dm_win;
    assign bus.pf_ar_ready   = pf_win;
    assign bus.m_ar_valid    = (state_q == HOLD);
    assign bus.m_ar_addr     = addr_q;
    assign bus.m_ar_len      = len_q;
    assign bus.m_ar_id       = id_q;
    assign bus.m_ar_src      = src_q;
    assign bus.outstanding   = outst_q;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_ar_issue_arbiter.sv
// Bench for ar_issue_arbiter: directed stimulus with hand-computed grant
// patterns; every expected grant pushes its payload into a scoreboard queue
// and an independent monitor pops it when the master AR handshake fires.
module tb_ar_issue_arbiter;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic        src;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    req_t sb[$];

    ar_issue_arbiter_if #(
        .ADDR_BITS(64), .TID_WIDTH(8), .BURST_LEN_WIDTH(8), .OUTST_WIDTH(3)
    ) bus ();

    ar_issue_arbiter #(
        .ADDR_BITS(64), .TID_WIDTH(8), .BURST_LEN_WIDTH(8),
        .STARVE_LIMIT(4), .OUTST_WIDTH(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic r_beat(input logic on);
        bus.m_r_valid = on;
        bus.m_r_ready = on;
        bus.m_r_last  = on;
    endtask

    // Check the readies for this cycle against the bench's expected winner,
    // record the expected issue, then advance past the edge and move the
    // winner on to its next payload.
    task automatic expect_grant(input logic d, input logic p, input string tag);
        @(negedge clk);
        chk({tag, " dm_ar_ready"}, 64'(bus.dm_ar_ready), 64'(d));
        chk({tag, " pf_ar_ready"}, 64'(bus.pf_ar_ready), 64'(p));
        if (d) sb.push_back('{bus.dm_ar_addr, bus.dm_ar_len, bus.dm_ar_id, 1'b0});
        if (p) sb.push_back('{bus.pf_ar_addr, bus.pf_ar_len, bus.pf_ar_id, 1'b1});
        step();
        if (d) begin
            bus.dm_ar_addr += 64'h40;
            bus.dm_ar_id   += 8'd1;
        end
        if (p) begin
            bus.pf_ar_addr += 64'h40;
            bus.pf_ar_id   += 8'd1;
        end
    endtask

    // Monitor: every accepted master request must match the oldest expected one
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.m_ar_valid && bus.m_ar_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue: unexpected request addr=%0h src=%0d, none expected",
                             bus.m_ar_addr, bus.m_ar_src);
                end else begin
                    e = sb.pop_front();
                    chk("issue addr", bus.m_ar_addr, e.addr);
                    chk("issue len",  64'(bus.m_ar_len), 64'(e.len));
                    chk("issue id",   64'(bus.m_ar_id),  64'(e.id));
                    chk("issue src",  64'(bus.m_ar_src), 64'(e.src));
                end
            end
        end
    end

    logic [63:0] held;

    initial begin
        bus.en = 1'b1;
        bus.dm_ar_valid = 1'b0; bus.dm_ar_addr = '0; bus.dm_ar_len = '0; bus.dm_ar_id = '0;
        bus.pf_ar_valid = 1'b0; bus.pf_ar_addr = '0; bus.pf_ar_len = '0; bus.pf_ar_id = '0;
        bus.m_ar_ready = 1'b1;
        r_beat(1'b0);

        #12;
        chk("reset m_ar_valid",    64'(bus.m_ar_valid), 64'd0);
        chk("reset m_ar_addr",     bus.m_ar_addr, 64'd0);
        chk("reset outstanding",   64'(bus.outstanding), 64'd0);
        chk("reset err_underflow", 64'(bus.err_underflow), 64'd0);
        #11 rst = 1'b0;
        step();

        // Demand only
        bus.dm_ar_valid = 1'b1;
        bus.dm_ar_addr  = 64'hdeadbeef;
        bus.dm_ar_len   = 8'd3;
        bus.dm_ar_id    = 8'd5;
        expect_grant(1'b1, 1'b0, "demand");
        bus.dm_ar_valid = 1'b0;
        @(negedge clk);
        chk("demand m_ar_valid", 64'(bus.m_ar_valid), 64'd1);
        chk("demand m_ar_addr",  bus.m_ar_addr, 64'hdeadbeef);
        chk("demand m_ar_len",   64'(bus.m_ar_len), 64'd3);
        chk("demand m_ar_id",    64'(bus.m_ar_id), 64'd5);
        chk("demand m_ar_src",   64'(bus.m_ar_src), 64'd0);
        chk("demand outstanding", 64'(bus.outstanding), 64'd1);
        for (int i = 0; i < 4; i++) begin
            bus.m_r_valid = 1'b1;
            bus.m_r_ready = 1'b1;
            bus.m_r_last  = (i == 3);
            step();
            chk("r beats outstanding", 64'(bus.outstanding), (i == 3) ? 64'd0 : 64'd1);
        end
        r_beat(1'b0);

        // Starvation: D,D,D,D,P repeating; completions keep the counter at 0
        bus.pf_ar_addr = 64'h1000; bus.pf_ar_len = 8'd7; bus.pf_ar_id = 8'h80;
        bus.dm_ar_valid = 1'b1;
        bus.pf_ar_valid = 1'b1;
        r_beat(1'b1);
        for (int k = 0; k < 10; k++) begin
            expect_grant((k % 5) != 4, (k % 5) == 4, "starve");
        end
        // Last grant was a prefetch; it still issues with en low
        bus.en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expect_grant(1'b1, 1'b0, "en_off");
        end
        bus.dm_ar_valid = 1'b0;
        bus.pf_ar_valid = 1'b0;
        r_beat(1'b0);
        step();
        step();
        chk("starve outstanding", 64'(bus.outstanding), 64'd0);
        chk("starve m_ar_valid",  64'(bus.m_ar_valid), 64'd0);
        chk("starve err",         64'(bus.err_underflow), 64'd0);

        // Backpressure then back-to-back drain
        bus.en = 1'b1;
        bus.m_ar_ready = 1'b0;
        bus.dm_ar_valid = 1'b1;
        bus.pf_ar_valid = 1'b1;
        held = bus.dm_ar_addr;
        expect_grant(1'b1, 1'b0, "bp fill");
        for (int k = 0; k < 5; k++) begin
            expect_grant(1'b0, 1'b0, "bp stall");
            chk("bp held addr",  bus.m_ar_addr, held);
            chk("bp held valid", 64'(bus.m_ar_valid), 64'd1);
        end
        bus.m_ar_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_grant(k != 3, k == 3, "b2b");
            chk("b2b valid", 64'(bus.m_ar_valid), 64'd1);
        end
        bus.dm_ar_valid = 1'b0;
        bus.pf_ar_valid = 1'b0;
        step();
        chk("b2b outstanding", 64'(bus.outstanding), 64'd5);
        chk("b2b idle", 64'(bus.m_ar_valid), 64'd0);

        // Cap at 7 bursts in flight
        r_beat(1'b1);
        repeat (5) step();
        r_beat(1'b0);
        chk("cap drain", 64'(bus.outstanding), 64'd0);
        bus.dm_ar_valid = 1'b1;
        for (int k = 0; k < 7; k++) expect_grant(1'b1, 1'b0, "cap fill");
        expect_grant(1'b0, 1'b0, "cap full");
        expect_grant(1'b0, 1'b0, "cap full");
        chk("cap outstanding", 64'(bus.outstanding), 64'd7);
        r_beat(1'b1);
        expect_grant(1'b0, 1'b0, "cap dec");
        r_beat(1'b0);
        chk("cap after dec", 64'(bus.outstanding), 64'd6);
        expect_grant(1'b1, 1'b0, "cap one");
        expect_grant(1'b0, 1'b0, "cap refull");
        chk("cap refull", 64'(bus.outstanding), 64'd7);
        r_beat(1'b1);
        expect_grant(1'b0, 1'b0, "cap dec2");
        expect_grant(1'b1, 1'b0, "cap inc_dec");
        r_beat(1'b0);
        bus.dm_ar_valid = 1'b0;
        chk("cap inc_dec", 64'(bus.outstanding), 64'd6);
        step();
        r_beat(1'b1);
        repeat (6) step();
        r_beat(1'b0);
        chk("cap final drain", 64'(bus.outstanding), 64'd0);
        chk("cap no err", 64'(bus.err_underflow), 64'd0);

        // Underflow
        r_beat(1'b1);
        step();
        r_beat(1'b0);
        chk("underflow err", 64'(bus.err_underflow), 64'd1);
        chk("underflow outstanding", 64'(bus.outstanding), 64'd0);
        step();
        step();
        chk("underflow sticky", 64'(bus.err_underflow), 64'd1);

        // Asynchronous reset with a request held
        bus.m_ar_ready = 1'b0;
        bus.dm_ar_valid = 1'b1;
        expect_grant(1'b1, 1'b0, "rst fill");
        bus.dm_ar_valid = 1'b0;
        chk("rst held valid", 64'(bus.m_ar_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst m_ar_valid",   64'(bus.m_ar_valid), 64'd0);
        chk("rst m_ar_addr",    bus.m_ar_addr, 64'd0);
        chk("rst m_ar_len",     64'(bus.m_ar_len), 64'd0);
        chk("rst m_ar_id",      64'(bus.m_ar_id), 64'd0);
        chk("rst m_ar_src",     64'(bus.m_ar_src), 64'd0);
        chk("rst outstanding",  64'(bus.outstanding), 64'd0);
        chk("rst err",          64'(bus.err_underflow), 64'd0);
        sb.delete();
        bus.m_ar_ready = 1'b1;
        #10 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post rst idle", 64'(bus.m_ar_valid), 64'd0);
        end

        chk("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
